// File: rtl/aes_round_mix_stage_if.sv
// Handshake and data bundle for the AES round back-half stage.
// The upstream producer / downstream consumer side is "master"; the stage itself is "slave".
interface aes_round_mix_stage_if;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] sb_data;
  logic [0:127] round_key;
  logic         last_round;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] out_data;

  modport slave (
    input  in_valid,
    input  sb_data,
    input  round_key,
    input  last_round,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

  modport master (
    output in_valid,
    output sb_data,
    output round_key,
    output last_round,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/aes_round_mix_stage.sv
// AES encryption round back-half: ShiftRows, MixColumns (bypassed on the final
// round) and AddRoundKey, split over two registered stages with valid/ready flow.
// Byte k of every 128-bit bus occupies bits [8k:8k+7]; the state is column-major
// (row = k mod 4, col = k div 4).
module aes_round_mix_stage (
  input  logic                  clk,
  input  logic                  rst,
  aes_round_mix_stage_if.slave  bus
);

  // GF(2^8) doubling, reduction polynomial 0x11B
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  logic [0:127] sr_data;
  logic [0:127] mc_data;
  logic [0:127] s1_data_next;

  logic         s1_valid_reg;
  logic [0:127] s1_data_reg;
  logic [0:127] s1_key_reg;
  logic         s2_valid_reg;
  logic [0:127] s2_data_reg;

  logic s2_free;
  logic s1_adv;
  logic in_xfer;
  logic out_xfer;

  // ShiftRows is pure wiring: output (r,c) takes input (r,(c+r) mod 4)
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_shift_rows
      localparam int ROW = gi % 4;
      localparam int COL = gi / 4;
      localparam int SRC = 4 * ((COL + ROW) % 4) + ROW;
      assign sr_data[8*gi +: 8] = bus.sb_data[8*SRC +: 8];
    end
  endgenerate

  // MixColumns, one circulant matrix multiply per state column
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_mix_columns
      logic [7:0] b0, b1, b2, b3;
      assign b0 = sr_data[32*gi      +: 8];
      assign b1 = sr_data[32*gi + 8  +: 8];
      assign b2 = sr_data[32*gi + 16 +: 8];
      assign b3 = sr_data[32*gi + 24 +: 8];
      assign mc_data[32*gi      +: 8] = xtime(b0) ^ mul3(b1) ^ b2 ^ b3;
      assign mc_data[32*gi + 8  +: 8] = b0 ^ xtime(b1) ^ mul3(b2) ^ b3;
      assign mc_data[32*gi + 16 +: 8] = b0 ^ b1 ^ xtime(b2) ^ mul3(b3);
      assign mc_data[32*gi + 24 +: 8] = mul3(b0) ^ b1 ^ b2 ^ xtime(b3);
    end
  endgenerate

  // The final round skips MixColumns; the flag is sampled with the block
  assign s1_data_next = bus.last_round ? sr_data : mc_data;

  // Flow control: a stage may advance when the stage after it is empty or draining
  assign s2_free  = !s2_valid_reg || bus.out_ready;
  assign s1_adv   = s1_valid_reg && s2_free;
  assign in_xfer  = bus.in_valid && bus.in_ready;
  assign out_xfer = s2_valid_reg && bus.out_ready;

  assign bus.in_ready  = !s1_valid_reg || s1_adv;
  assign bus.out_valid = s2_valid_reg;
  assign bus.out_data  = s2_data_reg;

  // Stage 1: capture the mixed state and its round key on an input transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
      s1_key_reg   <= '0;
    end else if (in_xfer) begin
      s1_valid_reg <= 1'b1;
      s1_data_reg  <= s1_data_next;
      s1_key_reg   <= bus.round_key;
    end else if (s1_adv) begin
      s1_valid_reg <= 1'b0;
    end
  end

  // Stage 2: AddRoundKey into the output register; holds while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
      s2_data_reg  <= '0;
    end else if (s1_adv) begin
      s2_valid_reg <= 1'b1;
      s2_data_reg  <= s1_data_reg ^ s1_key_reg;
    end else if (out_xfer) begin
      s2_valid_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aes_round_mix_stage.sv
// Directed testbench for aes_round_mix_stage: known AES vectors, backpressure,
// streaming throughput and mid-stream reset.
module tb_aes_round_mix_stage;

  logic clk = 1'b0;
  logic rst;

  aes_round_mix_stage_if bus();

  aes_round_mix_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [0:127] exp_q[$];

  // Reference: generic GF(2^8) shift-and-add multiply
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Reference round on a 4x4 state matrix
  function automatic logic [0:127] ref_round(input logic [0:127] sb, input logic [0:127] key,
                                             input logic last);
    logic [7:0] st [4][4];
    logic [7:0] sr [4][4];
    logic [7:0] mx [4][4];
    logic [0:127] res;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        st[r][c] = sb[8*(4*c+r) +: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        sr[r][c] = st[r][(c+r)%4];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        mx[r][c] = last ? sr[r][c]
                        : gmul(8'h02, sr[r][c]) ^ gmul(8'h03, sr[(r+1)%4][c]) ^
                          sr[(r+2)%4][c] ^ sr[(r+3)%4][c];
    res = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        res[8*(4*c+r) +: 8] = mx[r][c] ^ key[8*(4*c+r) +: 8];
    return res;
  endfunction

  function automatic logic [0:127] mk_sb(input int i);
    logic [7:0] t;
    t = i[7:0];
    return 128'h3243f6a8885a308d313198a2e0370734 ^ {16{t}};
  endfunction

  function automatic logic [0:127] mk_key(input int i);
    logic [31:0] w;
    w = 32'(i) * 32'h9e3779b9;
    return 128'h2b7e151628aed2a6abf7158809cf4f3c ^ {4{w}};
  endfunction

  function automatic logic mk_last(input int i);
    return i[0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [0:127] sb, input logic [0:127] key,
                       input logic last);
    bus.in_valid   = v;
    bus.sb_data    = sb;
    bus.round_key  = key;
    bus.last_round = last;
  endtask

  // Reset state; inputs offered during reset must not be captured
  task automatic test_reset();
    rst = 1'b1;
    bus.out_ready = 1'b0;
    drive(1'b1, 128'hffeeddccbbaa99887766554433221100, 128'h0123456789abcdef0123456789abcdef, 1'b0);
    step();
    step();
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    checks++;
    if (bus.out_data !== 128'h0) begin
      errors++; $display("FAIL reset_out_data: got %h expected 0", bus.out_data);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL reset_no_capture: cycle %0d out_valid %b expected 0", i, bus.out_valid);
      end
    end
    $display("test_reset done");
  endtask

  // Hand-computed vectors: FIPS-197 round 1, MixColumns column, final-round bypass
  task automatic test_known_vectors();
    logic [0:127] sb_tab  [3];
    logic [0:127] key_tab [3];
    logic         last_tab[3];
    logic [0:127] exp_tab [3];
    string        name_tab[3];
    sb_tab[0] = 128'hd42711aee0bf98f1b8b45de51e415230;
    key_tab[0] = 128'ha0fafe1788542cb123a339392a6c7605;
    last_tab[0] = 1'b0;
    exp_tab[0] = 128'ha49c7ff2689f352b6b5bea43026a5049;
    name_tab[0] = "fips_round1";
    sb_tab[1] = {4{32'hdb135345}};
    key_tab[1] = '0;
    last_tab[1] = 1'b0;
    exp_tab[1] = {4{32'h8e4da1bc}};
    name_tab[1] = "mixcolumns";
    sb_tab[2] = 128'h000102030405060708090a0b0c0d0e0f;
    key_tab[2] = '0;
    last_tab[2] = 1'b1;
    exp_tab[2] = 128'h00050a0f04090e03080d02070c01060b;
    name_tab[2] = "final_round";
    bus.out_ready = 1'b1;
    for (int v = 0; v < 3; v++) begin
      drive(1'b1, sb_tab[v], key_tab[v], last_tab[v]);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++; $display("FAIL %s_in_ready: got %b expected 1", name_tab[v], bus.in_ready);
      end
      step();
      drive(1'b0, '0, '0, 1'b0);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL %s_early_valid: got %b expected 0 one cycle after accept", name_tab[v], bus.out_valid);
      end
      step();
      checks++;
      if (bus.out_valid !== 1'b1) begin
        errors++; $display("FAIL %s_latency: out_valid %b expected 1", name_tab[v], bus.out_valid);
      end
      checks++;
      if (bus.out_data !== exp_tab[v]) begin
        errors++; $display("FAIL %s_data: got %h expected %h", name_tab[v], bus.out_data, exp_tab[v]);
      end
      $display("vector %s: out_data=%h", name_tab[v], bus.out_data);
      step();
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL %s_drain: out_valid %b expected 0", name_tab[v], bus.out_valid);
      end
    end
  endtask

  // Stall with both stages full, then drain, then alternating out_ready
  task automatic test_backpressure();
    int sent;
    int got;
    logic [0:127] expv;
    sent = 0;
    got = 0;
    exp_q.delete();
    bus.out_ready = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      drive(1'b1, mk_sb(sent), mk_key(sent), mk_last(sent));
      #1;
      if (bus.in_ready) begin
        exp_q.push_back(ref_round(mk_sb(sent), mk_key(sent), mk_last(sent)));
        sent++;
      end
      step();
    end
    drive(1'b1, mk_sb(sent), mk_key(sent), mk_last(sent));
    #1;
    checks++;
    if (sent != 2) begin
      errors++; $display("FAIL bp_accept_count: got %0d accepts expected 2", sent);
    end
    for (int h = 0; h < 3; h++) begin
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_in_ready: hold %0d got %b expected 0", h, bus.in_ready);
      end
      checks++;
      if (bus.out_valid !== 1'b1 || exp_q.size() == 0 || bus.out_data !== exp_q[0]) begin
        errors++; $display("FAIL bp_hold_data: hold %0d valid %b data %h expected first block", h, bus.out_valid, bus.out_data);
      end
      step();
      #1;
    end
    // drain and push the remaining blocks, then alternate out_ready
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      bus.out_ready = (got < 4) ? 1'b1 : cyc[0];
      if (sent < 8) drive(1'b1, mk_sb(sent), mk_key(sent), mk_last(sent));
      else drive(1'b0, '0, '0, 1'b0);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bp_order: unexpected output %h with nothing outstanding", bus.out_data);
        end else begin
          expv = exp_q.pop_front();
          if (bus.out_data !== expv) begin
            errors++; $display("FAIL bp_order: block %0d got %h expected %h", got, bus.out_data, expv);
          end
        end
        $display("bp out %0d: %h", got, bus.out_data);
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_round(mk_sb(sent), mk_key(sent), mk_last(sent)));
        sent++;
      end
      step();
    end
    checks++;
    if (got != 8 || sent != 8) begin
      errors++; $display("FAIL bp_complete: got %0d outputs from %0d sent expected 8", got, sent);
    end
    drive(1'b0, '0, '0, 1'b0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL bp_duplicate: extra out_valid with data %h", bus.out_data);
      end
      step();
    end
  endtask

  // Eight consecutive blocks with out_ready held high
  task automatic test_back_to_back();
    int sent;
    int got;
    int first;
    int last;
    logic [0:127] expv;
    sent = 0; got = 0; first = -1; last = -1;
    exp_q.delete();
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (sent < 8) drive(1'b1, mk_sb(100 + sent), mk_key(100 + sent), mk_last(sent / 3));
      else drive(1'b0, '0, '0, 1'b0);
      #1;
      if (bus.in_valid) begin
        checks++;
        if (bus.in_ready !== 1'b1) begin
          errors++; $display("FAIL b2b_in_ready: cycle %0d got %b expected 1", cyc, bus.in_ready);
        end
      end
      if (bus.out_valid) begin
        if (first < 0) first = cyc;
        last = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_data: unexpected output %h", bus.out_data);
        end else begin
          expv = exp_q.pop_front();
          if (bus.out_data !== expv) begin
            errors++; $display("FAIL b2b_data: block %0d got %h expected %h", got, bus.out_data, expv);
          end
        end
        $display("b2b out %0d at cycle %0d: %h", got, cyc, bus.out_data);
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_round(mk_sb(100 + sent), mk_key(100 + sent), mk_last(sent / 3)));
        sent++;
      end
      step();
    end
    checks++;
    if (got != 8) begin
      errors++; $display("FAIL b2b_count: got %0d outputs expected 8", got);
    end
    checks++;
    if (first != 2 || last - first != 7) begin
      errors++; $display("FAIL b2b_timing: first %0d last %0d expected 2 and 9", first, last);
    end
  endtask

  // Reset with two blocks in flight discards both
  task automatic test_reset_midstream();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, mk_sb(200 + i), mk_key(200 + i), 1'b0);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++; $display("FAIL rst_mid_fill: block %0d in_ready %b expected 1", i, bus.in_ready);
      end
      step();
    end
    rst = 1'b1;
    drive(1'b1, mk_sb(202), mk_key(202), 1'b1);
    step();
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_out_valid: got %b expected 0", bus.out_valid);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_in_ready: got %b expected 1", bus.in_ready);
    end
    checks++;
    if (bus.out_data !== 128'h0) begin
      errors++; $display("FAIL rst_mid_out_data: got %h expected 0", bus.out_data);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL rst_mid_discard: cycle %0d stale output %h", i, bus.out_data);
      end
    end
    $display("test_reset_midstream done");
  endtask

  initial begin
    rst = 1'b1;
    bus.out_ready = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    test_reset();
    test_known_vectors();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_round_mix_stage.md
Name: aes_round_mix_stage

Overview:
- Pipelined AES encryption round back-half; sits directly downstream of the 128-bit SubBytes stage and consumes its output.
- Applies ShiftRows, then MixColumns (skipped on the final round), then AddRoundKey, over two registered stages with valid/ready flow control.
- Its output feeds the round register / next round's SubBytes input.

Parameters:
- None. The datapath is fixed at 128 bits, AES-128/192/256 agnostic.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  sb_data, round_key and last_round are valid this cycle.
- in_ready  output  1  block accepts input this cycle.
- sb_data  input  [0:127]  SubBytes output. Byte k = sb_data[8k:8k+7]. State is column-major: row = k mod 4, col = k div 4.
- round_key  input  [0:127]  round key, same byte order.
- last_round  input  1  1 = final round: bypass MixColumns.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  [0:127]  round result, same byte order.

Behaviour:
- Transfers: an input transfer happens when in_valid && in_ready. An output transfer happens when out_valid && out_ready.
- ShiftRows (combinational on sb_data): out(r,c) = in(r,(c+r) mod 4). In byte-index order the output is bytes 0,5,10,15 | 4,9,14,3 | 8,13,2,7 | 12,1,6,11.
- MixColumns over GF(2^8), polynomial 0x11B, applied per column (s0..s3):
  - s0' = 2s0^3s1^s2^s3
  - s1' = s0^2s1^3s2^s3
  - s2' = s0^s1^2s2^3s3
  - s3' = 3s0^s1^s2^2s3
  - xtime(b) = (b<<1) ^ (b[msb] ? 0x1B : 0). 3b = xtime(b) ^ b.
- Stage 1 register (s1_valid, s1_data, s1_key):
  - s1_data = last_round ? ShiftRows(sb_data) : MixColumns(ShiftRows(sb_data)).
  - s1_key = round_key.
  - Both load on an input transfer.
- Stage 2 register (s2_valid, s2_data): s2_data = s1_data ^ s1_key, loaded when stage 1 advances. out_data = s2_data, out_valid = s2_valid.
- Advance rules:
  - s2_free = !s2_valid || out_ready.
  - s1_adv = s1_valid && s2_free.
  - in_ready = !s1_valid || s1_adv.
  - in_ready is combinational from out_ready; no combinational path from in_valid to out_valid.
- Valid update:
  - s2_valid: set on s1_adv. Otherwise cleared on an output transfer.
  - s1_valid: set on an input transfer. Otherwise cleared on s1_adv.
  - A simultaneous input transfer and s1_adv keeps s1_valid = 1 with new data.
- Latency: 2 cycles from input transfer to out_valid, with no backpressure. Throughput is 1 block per cycle when out_ready is held 1.
- Backpressure:
  - Both stages full and out_ready = 0: in_ready = 0, and all registers hold their values.
  - At most 2 blocks are in flight. No data is dropped or duplicated.
  - out_data is stable while out_valid && !out_ready.
- Reset:
  - Synchronous, active-high. Clears s1_valid and s2_valid, so out_valid = 0 and in_ready = 1 in the cycle after rst.
  - Data registers are cleared to 0; out_data = 0 after reset.
  - Reset mid-operation discards all in-flight blocks. Inputs presented while rst = 1 are not captured.
- last_round is sampled per block at the input transfer and travels with it, so rounds may be interleaved freely.

Test Plan:
- FIPS-197 App. B round 1: sb_data = d42711aee0bf98f1b8b45de51e415230, round_key = a0fafe1788542cb123a339392a6c7605, last_round = 0, out_ready = 1 -> out_valid 2 cycles later with out_data = a49c7ff2689f352b6b5bea43026a5049.
- MixColumns column check: sb_data = db135345 repeated 4x, key = 0, last_round = 0 -> out_data = 8e4da1bc repeated 4x.
- Final-round bypass: sb_data = 000102030405060708090a0b0c0d0e0f, key = 0, last_round = 1 -> out_data = 00050a0f04090e03080d02070c01060b.
- Backpressure: stream 4 distinct blocks with in_valid = 1 and out_ready = 0.
  - Expect in_ready to drop to 0 after 2 accepts, with out_data held stable.
  - Then raise out_ready -> all 4 blocks exit in order, none lost or duplicated.
  - Alternating out_ready 1/0 -> output order preserved.
- Back-to-back throughput: 8 consecutive blocks with out_ready = 1 -> 8 consecutive out_valid cycles, each result matching the reference model.
- Reset mid-stream: assert rst for 1 cycle while 2 blocks are in flight -> out_valid = 0, in_ready = 1, out_data = 0 next cycle, and neither in-flight block ever appears at the output.
